// File: rtl/grid_plot_ctrl.sv
`timescale 1ns/1ps
// grid_plot_ctrl
// Drives the write port of a VGA adapter to render a GRID_SIZE x GRID_SIZE
// cell grid, each cell PIXEL_SIZE x PIXEL_SIZE VGA pixels. Three operations:
//   clear  : fill the whole grid area with colour 3'b000
//   cell   : paint one cell with a given colour
//   redraw : repaint every cell from image memory (nonzero word -> 3'b111)
//
// Ports
//   CLOCK_50                  clock, all state on the rising edge
//   resetn                    asynchronous active-low reset
//   clear_req/cell_req/redraw_req  level requests, sampled only when idle
//   cell_x, cell_y, cell_colour    cell operation arguments, latched on accept
//   mem_address / mem_rdata   image memory port (read data one cycle later)
//   clear_ack/cell_ack/redraw_ack  one-cycle acceptance pulses
//   busy                      high from the cycle after accept through done
//   done                      pulse on the final cycle of an operation
//   vga_x, vga_y, vga_colour, vga_plot  registered VGA write port
module grid_plot_ctrl #(
  parameter int GRID_SIZE     = 28,
  parameter int PIXEL_SIZE    = 4,
  parameter int GRID_OFFSET_X = 16,
  parameter int GRID_OFFSET_Y = 12
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        clear_req,
  input  logic        cell_req,
  input  logic [4:0]  cell_x,
  input  logic [4:0]  cell_y,
  input  logic [2:0]  cell_colour,
  input  logic        redraw_req,
  output logic [15:0] mem_address,
  input  logic [31:0] mem_rdata,
  output logic        clear_ack,
  output logic        cell_ack,
  output logic        redraw_ack,
  output logic        busy,
  output logic        done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CELL, S_FETCH, S_WAIT, S_PAINT
  } state_t;

  localparam logic [9:0]  PIX_LAST  = 10'(PIXEL_SIZE - 1);
  localparam logic [9:0]  AREA_LAST = 10'(GRID_SIZE * PIXEL_SIZE - 1);
  localparam logic [9:0]  GRID_LIM  = 10'(GRID_SIZE);
  localparam logic [9:0]  GRID_LAST = 10'(GRID_SIZE - 1);
  localparam logic [15:0] CELL_LAST = 16'(GRID_SIZE * GRID_SIZE - 1);

  state_t      state_q, state_nx;
  logic [9:0]  px_q, px_nx, py_q, py_nx;   // pixel offset within area / cell
  logic [9:0]  cx_q, cx_nx, cy_q, cy_nx;   // current cell coordinates
  logic [15:0] idx_q, idx_nx;              // redraw cell index (row-major)
  logic [2:0]  col_q, col_nx;              // colour of the cell being drawn

  logic        plot_nx, done_nx, busy_nx;
  logic [7:0]  x_nx;
  logic [6:0]  y_nx;
  logic [2:0]  colour_nx;
  logic [15:0] addr_nx;

  logic        pix_last, cell_bad;
  logic        pix_last_nx, cell_bad_nx;
  int          x_full, y_full;

  // Acks are combinational so they land in the accepting idle cycle itself;
  // gating with resetn keeps them low while reset is held with a request up.
  assign clear_ack  = resetn && (state_q == S_IDLE) && clear_req;
  assign cell_ack   = resetn && (state_q == S_IDLE) && !clear_req && cell_req;
  assign redraw_ack = resetn && (state_q == S_IDLE) && !clear_req && !cell_req
                      && redraw_req;

  assign pix_last = (px_q == PIX_LAST) && (py_q == PIX_LAST);
  assign cell_bad = (cx_q >= GRID_LIM) || (cy_q >= GRID_LIM);

  // Next-state and counter update
  always_comb begin
    state_nx = state_q;
    px_nx    = px_q;
    py_nx    = py_q;
    cx_nx    = cx_q;
    cy_nx    = cy_q;
    idx_nx   = idx_q;
    col_nx   = col_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_nx = S_CLEAR;
          px_nx    = '0;
          py_nx    = '0;
        end else if (cell_req) begin
          state_nx = S_CELL;
          px_nx    = '0;
          py_nx    = '0;
          cx_nx    = 10'(cell_x);
          cy_nx    = 10'(cell_y);
          col_nx   = cell_colour;
        end else if (redraw_req) begin
          state_nx = S_FETCH;
          idx_nx   = '0;
          cx_nx    = '0;
          cy_nx    = '0;
        end
      end
      S_CLEAR: begin
        if (px_q == AREA_LAST) begin
          px_nx = '0;
          if (py_q == AREA_LAST) state_nx = S_IDLE;
          else                   py_nx    = py_q + 10'd1;
        end else begin
          px_nx = px_q + 10'd1;
        end
      end
      S_CELL: begin
        // An out-of-range cell was acked but plots nothing: one cycle here.
        if (cell_bad || pix_last) begin
          state_nx = S_IDLE;
        end else if (px_q == PIX_LAST) begin
          px_nx = '0;
          py_nx = py_q + 10'd1;
        end else begin
          px_nx = px_q + 10'd1;
        end
      end
      S_FETCH: state_nx = S_WAIT;
      S_WAIT: begin
        state_nx = S_PAINT;
        px_nx    = '0;
        py_nx    = '0;
        col_nx   = (mem_rdata != 32'd0) ? 3'b111 : 3'b000;
      end
      S_PAINT: begin
        if (pix_last) begin
          if (idx_q == CELL_LAST) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_FETCH;
            idx_nx   = idx_q + 16'd1;
            if (cx_q == GRID_LAST) begin
              cx_nx = '0;
              cy_nx = cy_q + 10'd1;
            end else begin
              cx_nx = cx_q + 10'd1;
            end
          end
        end else if (px_q == PIX_LAST) begin
          px_nx = '0;
          py_nx = py_q + 10'd1;
        end else begin
          px_nx = px_q + 10'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output values for the cycle being entered, so the VGA port registers
  // line up with the state that produces them.
  always_comb begin
    pix_last_nx = (px_nx == PIX_LAST) && (py_nx == PIX_LAST);
    cell_bad_nx = (cx_nx >= GRID_LIM) || (cy_nx >= GRID_LIM);
    plot_nx     = 1'b0;
    done_nx     = 1'b0;
    busy_nx     = (state_nx != S_IDLE);
    colour_nx   = col_nx;
    addr_nx     = mem_address;
    x_full      = GRID_OFFSET_X + int'(cx_nx) * PIXEL_SIZE + int'(px_nx);
    y_full      = GRID_OFFSET_Y + int'(cy_nx) * PIXEL_SIZE + int'(py_nx);
    case (state_nx)
      S_CLEAR: begin
        x_full    = GRID_OFFSET_X + int'(px_nx);
        y_full    = GRID_OFFSET_Y + int'(py_nx);
        colour_nx = 3'b000;
        plot_nx   = 1'b1;
        done_nx   = (px_nx == AREA_LAST) && (py_nx == AREA_LAST);
      end
      S_CELL: begin
        plot_nx = !cell_bad_nx;
        done_nx = cell_bad_nx || pix_last_nx;
      end
      S_FETCH: addr_nx = idx_nx;
      S_PAINT: begin
        plot_nx = 1'b1;
        done_nx = pix_last_nx && (idx_nx == CELL_LAST);
      end
      default: ;
    endcase
    // Truncation to the adapter widths happens only here.
    x_nx = 8'(x_full);
    y_nx = 7'(y_full);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      idx_q       <= '0;
      col_q       <= '0;
      vga_plot    <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      mem_address <= '0;
    end else begin
      state_q     <= state_nx;
      px_q        <= px_nx;
      py_q        <= py_nx;
      cx_q        <= cx_nx;
      cy_q        <= cy_nx;
      idx_q       <= idx_nx;
      col_q       <= col_nx;
      vga_plot    <= plot_nx;
      vga_x       <= x_nx;
      vga_y       <= y_nx;
      vga_colour  <= colour_nx;
      done        <= done_nx;
      busy        <= busy_nx;
      mem_address <= addr_nx;
    end
  end

endmodule

// File: tb/tb_grid_plot_ctrl.sv
`timescale 1ns/1ps
module tb_grid_plot_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        clear_req = 1'b0, cell_req = 1'b0, redraw_req = 1'b0;
  logic [4:0]  cell_x = '0, cell_y = '0;
  logic [2:0]  cell_colour = '0;
  logic [15:0] mem_address;
  logic [31:0] mem_rdata = '0;
  logic        clear_ack, cell_ack, redraw_ack, busy, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  grid_plot_ctrl dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .clear_req(clear_req), .cell_req(cell_req),
    .cell_x(cell_x), .cell_y(cell_y), .cell_colour(cell_colour),
    .redraw_req(redraw_req),
    .mem_address(mem_address), .mem_rdata(mem_rdata),
    .clear_ack(clear_ack), .cell_ack(cell_ack), .redraw_ack(redraw_ack),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Image memory: data valid one cycle after the address.
  logic [31:0] mem [0:783];
  always @(posedge CLOCK_50)
    mem_rdata <= (mem_address < 16'd784) ? mem[mem_address[9:0]] : 32'h0;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       dn;
    int         blen;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int busy_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic push_ev(input logic plot, input int x, input int y,
                         input logic [2:0] col, input logic dn, input int blen);
    exp_t e;
    e.plot = plot; e.x = 8'(x); e.y = 7'(y); e.col = col; e.dn = dn; e.blen = blen;
    q.push_back(e);
  endtask

  task automatic push_clear();
    for (int yy = 0; yy < 112; yy++)
      for (int xx = 0; xx < 112; xx++)
        push_ev(1'b1, 16 + xx, 12 + yy, 3'b000, (xx == 111 && yy == 111), 12544);
  endtask

  task automatic push_cell(input int cx, input int cy, input logic [2:0] col);
    if (cx >= 28 || cy >= 28) push_ev(1'b0, 0, 0, 3'b000, 1'b1, 1);
    else
      for (int dy = 0; dy < 4; dy++)
        for (int dx = 0; dx < 4; dx++)
          push_ev(1'b1, 16 + cx * 4 + dx, 12 + cy * 4 + dy, col, (dx == 3 && dy == 3), 16);
  endtask

  task automatic push_redraw();
    for (int idx = 0; idx < 784; idx++) begin
      logic [2:0] c;
      c = (mem[idx] != 32'd0) ? 3'b111 : 3'b000;
      for (int dy = 0; dy < 4; dy++)
        for (int dx = 0; dx < 4; dx++)
          push_ev(1'b1, 16 + (idx % 28) * 4 + dx, 12 + (idx / 28) * 4 + dy, c,
                  (idx == 783 && dx == 3 && dy == 3), 14112);
    end
  endtask

  // Stimulus side of the scoreboard: expectations queued on acceptance.
  always @(negedge CLOCK_50) begin
    if (resetn) begin
      if (clear_ack)  push_clear();
      if (cell_ack)   push_cell(int'(cell_x), int'(cell_y), cell_colour);
      if (redraw_ack) push_redraw();
    end
  end

  // Monitor: every plot or done cycle consumes one expectation.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (!resetn) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (vga_plot || done) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {30'd0, vga_plot, done}, 32'd0);
        end else begin
          e = q.pop_front();
          if (e.plot)
            chk("plot", {12'd0, vga_plot, vga_x, vga_y, vga_colour, done},
                {12'd0, 1'b1, e.x, e.y, e.col, e.dn});
          else
            chk("noplot", {30'd0, vga_plot, done}, 32'd1);
          if (e.dn) begin
            chk("busy_len", busy_run, e.blen);
            busy_run = 0;
          end
        end
      end
    end
  end

  task automatic next_ack(input string nm, input logic [2:0] want);
    @(negedge CLOCK_50);
    chk(nm, {29'd0, clear_ack, cell_ack, redraw_ack}, {29'd0, want});
  endtask

  task automatic wait_done(input string nm, input int budget, output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge CLOCK_50);
      cycles++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_cell(input string nm, input logic [4:0] x, input logic [4:0] y,
                         input logic [2:0] c, input int exp_cyc);
    int cyc;
    @(posedge CLOCK_50); #1;
    cell_req = 1'b1; cell_x = x; cell_y = y; cell_colour = c;
    next_ack({nm, "_ack"}, 3'b010);
    @(posedge CLOCK_50); #1;
    // Scramble the inputs: the block must have latched them.
    cell_req = 1'b0; cell_x = 5'd9; cell_y = 5'd9; cell_colour = 3'b010;
    wait_done(nm, 40, cyc);
    chk({nm, "_latency"}, cyc, exp_cyc);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 784; i++) mem[i] = 32'd0;
    mem[5] = 32'h0000_0100;

    // Reset state
    repeat (2) @(negedge CLOCK_50);
    chk("rst_ctrl", {26'd0, vga_plot, busy, done, clear_ack, cell_ack, redraw_ack}, 32'd0);
    chk("rst_xy", {12'd0, vga_x, vga_y, vga_colour, 2'b00}, 32'd0);
    chk("rst_addr", {16'd0, mem_address}, 32'd0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;

    // Single cells: corner, far corner, out-of-range x and y
    do_cell("cell00", 5'd0, 5'd0, 3'b111, 16);
    do_cell("cell2727", 5'd27, 5'd27, 3'b101, 16);
    do_cell("cellx28", 5'd28, 5'd3, 3'b110, 1);
    do_cell("celly31", 5'd3, 5'd31, 3'b001, 1);

    // Priority: all three requests at once
    @(posedge CLOCK_50); #1;
    clear_req = 1'b1; cell_req = 1'b1; redraw_req = 1'b1;
    cell_x = 5'd1; cell_y = 5'd2; cell_colour = 3'b011;
    next_ack("prio_clear_ack", 3'b100);
    @(posedge CLOCK_50); #1;
    clear_req = 1'b0;
    wait_done("prio_clear", 13000, cyc);
    chk("prio_clear_len", cyc, 12544);
    next_ack("prio_cell_ack", 3'b010);
    chk("prio_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge CLOCK_50); #1;
    cell_req = 1'b0;
    wait_done("prio_cell", 40, cyc);
    next_ack("prio_redraw_ack", 3'b001);
    @(posedge CLOCK_50); #1;
    redraw_req = 1'b0;
    wait_done("redraw_w5", 15000, cyc);
    chk("redraw_w5_len", cyc, 14112);

    // Reset in the middle of a clear, request still held
    @(posedge CLOCK_50); #1;
    clear_req = 1'b1;
    next_ack("rclr_ack", 3'b100);
    repeat (100) @(posedge CLOCK_50);
    #3 resetn = 1'b0;
    #1;
    chk("arst_ctrl", {26'd0, vga_plot, busy, done, clear_ack, cell_ack, redraw_ack}, 32'd0);
    chk("arst_xy", {12'd0, vga_x, vga_y, vga_colour, 2'b00}, 32'd0);
    chk("arst_addr", {16'd0, mem_address}, 32'd0);
    q.delete();
    @(negedge CLOCK_50);
    chk("arst_no_done", {31'd0, done}, 32'd0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    next_ack("rclr_reack", 3'b100);
    @(posedge CLOCK_50); #1;
    clear_req = 1'b0;
    wait_done("rclr", 13000, cyc);
    chk("rclr_len", cyc, 12544);

    // Back-to-back redraws with the request held
    @(posedge CLOCK_50); #1;
    redraw_req = 1'b1;
    next_ack("b2b_ack1", 3'b001);
    wait_done("b2b_1", 15000, cyc);
    mem[5] = 32'd0;
    mem[783] = 32'h8000_0000;
    next_ack("b2b_ack2", 3'b001);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge CLOCK_50); #1;
    redraw_req = 1'b0;
    wait_done("b2b_2", 15000, cyc);
    chk("b2b_2_len", cyc, 14112);

    repeat (3) @(negedge CLOCK_50);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
